// File: rtl/int_word_fifo.sv
// int_word_fifo
// Buffered hand-off between the UART word receiver and the UART word sender.
// Each rising edge of in_avail pushes in_data into a small circular FIFO.
// A read FSM pops one word at a time and pulses out_send whenever the sender
// is idle, then waits for the sender's busy/idle handshake before the next pop.

module int_word_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_avail,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_send,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             prev_avail;
  state_t           state;

  logic push_req;
  logic pop;
  logic push_ok;

  // Flags come straight from count so they can never disagree with it.
  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

  // A push is requested only on the rising edge of the receiver's level.
  assign push_req = in_avail && !prev_avail;

  // Pop only from IDLE on a non-empty FIFO; a word pushed this edge is not yet
  // counted, so it cannot be popped until the following edge.
  assign pop = (state == IDLE) && !empty && out_ready;

  // A full FIFO still accepts a word when a pop frees a slot on the same edge.
  assign push_ok = push_req && (!full || pop);

  // Storage write; pointers live in the control block below.
  // NOTE: the data array has no reset -- its contents are don't-care until
  // written and count/pointers alone decide what is valid, so leaving it out
  // keeps it a plain RAM instead of a wide bank of resettable flops.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Edge detect, pointers, occupancy, sticky overflow and the read FSM.
  // NOTE: every assignment here is non-blocking so all registers update from
  // the same pre-edge values (e.g. a pop at full reads the old mem[rd_ptr]
  // even though a push writes that same slot on this edge).
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_avail <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      out_data   <= '0;
      out_send   <= 1'b0;
      state      <= IDLE;
    end else begin
      prev_avail <= in_avail;
      out_send   <= 1'b0;

      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end

      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      unique case (state)
        IDLE: begin
          if (pop) begin
            out_data <= mem[rd_ptr];
            out_send <= 1'b1;
            rd_ptr   <= rd_ptr + 1'b1;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // Sender drops ready once it has taken the word.
          if (!out_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Sender raises ready again when the word is fully shifted out.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/int_word_fifo.md
# int_word_fifo

Buffered hand-off stage between the UART word receiver (`int_receiver`) and the UART word sender (`int_sender`). It captures each completed 32-bit word flagged by the receiver's `int_avail` level, queues it in a small circular FIFO, and issues it to the sender with a one-cycle send pulse whenever the sender reports ready. Words arriving back-to-back are therefore no longer lost while the sender is still shifting out a previous word.

## Interface
Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2
- AW, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  reset; synchronous, active-low (0 = reset)
- in_data  input  WIDTH  word from receiver (`o_int`)
- in_avail  input  1  receiver word-available level; only its rising edge is significant
- out_ready  input  1  sender idle indication (`int_ready`)
- out_data  output  WIDTH  word presented to sender (`data`)
- out_send  output  1  one-cycle send strobe to sender (`int_send`)
- count  output  AW+1  number of stored words, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full

## Operation
- Edge detect: register `prev_avail`; a push request exists when in_avail=1 and prev_avail=0 at a clock edge. A held-high in_avail produces exactly one push.
- Push: write in_data to mem[wr_ptr], increment wr_ptr modulo DEPTH.
- Push while full with no pop in the same cycle: word is discarded, pointers and count unchanged, overflow set to 1. overflow clears only on reset.
- Push while full with a pop in the same cycle: push accepted; count stays DEPTH.
- Read FSM, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if empty=0 and out_ready=1, load out_data <= mem[rd_ptr], assert out_send for one cycle, increment rd_ptr modulo DEPTH (pop), go WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: out_send=0. Stay until out_ready=0 (sender has accepted), then go WAIT_DONE.
  - WAIT_DONE: stay until out_ready=1, then go IDLE.
- out_data holds its last loaded value outside a send; it changes only on a pop.
- count: +1 on accepted push only, −1 on pop only, unchanged when both or neither occur. empty and full are registered or derived from count; they must be consistent with count in the same cycle.
- A push into an empty FIFO can never be popped in the same cycle. The word becomes eligible on the following edge.
- Reset mid-operation: all stored words are discarded, FSM returns to IDLE, and out_send is 0 after the reset edge, even if it was high.

## Timing
- Reset values: out_data=0, out_send=0, count=0, empty=1, full=0, overflow=0, prev_avail=0, wr_ptr=rd_ptr=0, state IDLE. Memory contents are don't-care.
- Latency: in_avail rises before edge k, and the push happens at edge k. With out_ready=1 and state IDLE, out_send=1 and out_data are valid after edge k+1, high for exactly one cycle.
- Minimum spacing between successive out_send pulses is 3 cycles: IDLE, then WAIT_BUSY for at least 1 cycle, then WAIT_DONE for at least 1 cycle.
- Throughput is bounded by the sender. Input acceptance is one word per in_avail rising edge and needs at least 2 cycles between edges.

## Test plan
- Single word: push 32'h41424344 with out_ready=1 → out_send pulses 2 edges later with out_data=32'h41424344; count goes 0→1→0.
- Burst while busy: hold out_ready=0 and push 32'h1, 32'h2, 32'h3 → count=3. Then raise out_ready and emulate sender handshakes → sends occur in order 1, 2, 3, ending with empty=1.
- Overflow: with out_ready=0, push 5 words (DEPTH=4) → full=1, count=4, overflow=1. The 5th word is never sent, and words 1–4 drain in order.
- Simultaneous push/pop at full: FIFO full, IDLE and out_ready=1 with a push on the same edge → count stays 4, overflow stays 0, and the pushed word is sent last.
- Held in_avail: hold in_avail high for 10 cycles → exactly one push, count=1.
- Reset mid-send: assert rst=0 on the edge where out_send=1 with 2 words queued → on the next edge out_send=0, count=0, empty=1, overflow=0, and no further sends occur.
